// File: rtl/upcounter_ctl.sv
// rtl/upcounter_ctl.sv - programmable up-counter with run control, one-shot/free-run and wrap tally
//
// Purpose: counts from a loadable value up to MAX_VAL. In free-run mode it
// wraps back to 0 and tallies the wrap. In one-shot mode it stops at MAX_VAL
// and flags completion. All outputs come straight from registers.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     start request (IDLE->RUN keeps count, DONE->RUN clears count)
//   en        count enable while running
//   oneshot   1 = stop at MAX_VAL, 0 = wrap to 0 (sampled on the terminal edge)
//   load      load request, highest priority after rst
//   load_val  value to load, clamped to MAX_VAL
//   count     current count
//   tc        one-cycle terminal-count pulse
//   busy      high while in RUN
//   done      high while in DONE
//   wrap_cnt  saturating count of wraps since reset

module upcounter_ctl #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wrap_cnt
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic [7:0]       wrap_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      tc       <= 1'b0;
      wrap_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      tc       <= tc_nxt;
      wrap_cnt <= wrap_nxt;
    end
  end

  // busy/done decode the state register only, so they stay glitch-free
  // and carry no path from the inputs.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tc_nxt    = 1'b0;
    wrap_nxt  = wrap_cnt;

    if (load) begin
      // Load wins over start/en and never raises tc, even when it lands on MAX.
      count_nxt = (load_val > MAX) ? MAX : load_val;
      if (state == DONE) begin
        state_nxt = IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = RUN;
          end
        end
        DONE: begin
          if (start) begin
            state_nxt = RUN;
            count_nxt = '0;
          end
        end
        RUN: begin
          // A terminal event with en=0 simply waits here until en returns.
          if (en) begin
            if (count == MAX) begin
              tc_nxt = 1'b1;
              if (oneshot) begin
                state_nxt = DONE;
              end else begin
                count_nxt = '0;
                if (wrap_cnt != 8'hFF) begin
                  wrap_nxt = wrap_cnt + 8'd1;
                end
              end
            end else begin
              count_nxt = count + ONE;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upcounter_ctl.sv
// tb/tb_upcounter_ctl.sv - scoreboard bench for upcounter_ctl across three parameter sets

module tb_upcounter_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       en;
  logic       oneshot;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] count_a;
  logic       tc_a, busy_a, done_a;
  logic [7:0] wrap_a;
  logic [3:0] count_b;
  logic       tc_b, busy_b, done_b;
  logic [7:0] wrap_b;
  logic [1:0] count_c;
  logic       tc_c, busy_c, done_c;
  logic [7:0] wrap_c;

  always #5 clk = ~clk;

  upcounter_ctl #(.WIDTH(4), .MAX_VAL(15)) u_max15 (
    .clk(clk), .rst(rst), .start(start), .en(en), .oneshot(oneshot),
    .load(load), .load_val(load_val),
    .count(count_a), .tc(tc_a), .busy(busy_a), .done(done_a), .wrap_cnt(wrap_a)
  );

  upcounter_ctl #(.WIDTH(4), .MAX_VAL(9)) u_max9 (
    .clk(clk), .rst(rst), .start(start), .en(en), .oneshot(oneshot),
    .load(load), .load_val(load_val),
    .count(count_b), .tc(tc_b), .busy(busy_b), .done(done_b), .wrap_cnt(wrap_b)
  );

  upcounter_ctl #(.WIDTH(2), .MAX_VAL(1)) u_max1 (
    .clk(clk), .rst(rst), .start(start), .en(en), .oneshot(oneshot),
    .load(load), .load_val(load_val[1:0]),
    .count(count_c), .tc(tc_c), .busy(busy_c), .done(done_c), .wrap_cnt(wrap_c)
  );

  typedef struct packed {
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;
    logic [7:0] wrap;
  } obs_t;

  int    sel;
  obs_t  got;
  obs_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  always_comb begin
    got = '0;
    case (sel)
      0:       got = '{count_a, tc_a, busy_a, done_a, wrap_a};
      1:       got = '{count_b, tc_b, busy_b, done_b, wrap_b};
      default: got = '{{2'b00, count_c}, tc_c, busy_c, done_c, wrap_c};
    endcase
  end

  // Monitor: every expectation queued before an edge is checked just after it.
  always @(posedge clk) begin
    obs_t  e;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got count=%0d tc=%0b busy=%0b done=%0b wrap=%0d, expected count=%0d tc=%0b busy=%0b done=%0b wrap=%0d",
                 nm, got.count, got.tc, got.busy, got.done, got.wrap,
                 e.count, e.tc, e.busy, e.done, e.wrap);
      end
    end
  end

  function automatic obs_t mk(input int c, input int t, input int b, input int d, input int w);
    obs_t o;
    o.count = 4'(c);
    o.tc    = (t != 0);
    o.busy  = (b != 0);
    o.done  = (d != 0);
    o.wrap  = 8'(w);
    return o;
  endfunction

  // Drive one cycle of inputs, queue the state expected after the next edge.
  task automatic step(input logic r, input logic s, input logic e, input logic o,
                      input logic l, input logic [3:0] lv, input obs_t ex, input string nm);
    rst      = r;
    start    = s;
    en       = e;
    oneshot  = o;
    load     = l;
    load_val = lv;
    exp_q.push_back(ex);
    name_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int c;
    int en_pat [4];
    rst = 1'b1; start = 1'b0; en = 1'b0; oneshot = 1'b0; load = 1'b0; load_val = 4'd0;
    en_pat = '{0, 1, 0, 1};

    // ---------------- MAX_VAL = 15 ----------------
    sel = 0;
    step(1, 1, 1, 1, 1, 4'd5, mk(0, 0, 0, 0, 0), "reset_1");
    step(1, 1, 1, 0, 1, 4'd12, mk(0, 0, 0, 0, 0), "reset_2");
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0, 4'd0, mk(0, 0, 0, 0, 0), "idle_hold");

    step(0, 1, 1, 0, 0, 4'd0, mk(0, 0, 1, 0, 0), "fr_start");
    for (int i = 1; i <= 34; i++)
      step(0, 0, 1, 0, 0, 4'd0, mk(i % 16, (i % 16) == 0, 1, 0, i / 16), "free_run");

    step(1, 0, 0, 0, 0, 4'd0, mk(0, 0, 0, 0, 0), "rst_clear");
    step(0, 1, 0, 0, 0, 4'd0, mk(0, 0, 1, 0, 0), "gap_start");
    for (int i = 1; i <= 7; i++) step(0, 0, 1, 0, 0, 4'd0, mk(i, 0, 1, 0, 0), "gap_count");
    c = 7;
    for (int i = 0; i < 4; i++) begin
      c = c + en_pat[i];
      step(0, 0, 1'(en_pat[i]), 0, 0, 4'd0, mk(c, 0, 1, 0, 0), "en_gap");
    end
    for (int i = 10; i <= 12; i++) step(0, 0, 1, 0, 0, 4'd0, mk(i, 0, 1, 0, 0), "to_twelve");
    step(1, 1, 1, 0, 0, 4'd0, mk(0, 0, 0, 0, 0), "rst_mid_run");
    step(0, 0, 1, 0, 0, 4'd0, mk(0, 0, 0, 0, 0), "idle_after_rst");

    // ---------------- MAX_VAL = 9 ----------------
    sel = 1;
    step(1, 0, 0, 0, 0, 4'd0, mk(0, 0, 0, 0, 0), "rst_b");
    step(0, 1, 1, 1, 0, 4'd0, mk(0, 0, 1, 0, 0), "os_start");
    for (int i = 1; i <= 9; i++) step(0, 0, 1, 1, 0, 4'd0, mk(i, 0, 1, 0, 0), "os_count");
    step(0, 0, 0, 1, 0, 4'd0, mk(9, 0, 1, 0, 0), "pending_hold");
    step(0, 0, 1, 1, 0, 4'd0, mk(9, 1, 0, 1, 0), "os_done");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 4'd0, mk(9, 0, 0, 1, 0), "done_hold");
    step(0, 1, 1, 0, 0, 4'd0, mk(0, 0, 1, 0, 0), "restart");
    for (int i = 1; i <= 3; i++) step(0, 0, 1, 0, 0, 4'd0, mk(i, 0, 1, 0, 0), "to_three");
    step(0, 1, 1, 0, 1, 4'd14, mk(9, 0, 1, 0, 0), "load_clamp");
    step(0, 0, 1, 0, 0, 4'd0, mk(0, 1, 1, 0, 1), "wrap_after_load");
    for (int i = 1; i <= 9; i++) step(0, 0, 1, 1, 0, 4'd0, mk(i, 0, 1, 0, 1), "os2_count");
    step(0, 0, 1, 1, 0, 4'd0, mk(9, 1, 0, 1, 1), "os2_done");
    step(0, 1, 1, 0, 1, 4'd9, mk(9, 0, 0, 0, 1), "load_from_done");
    step(0, 1, 1, 0, 0, 4'd0, mk(9, 0, 1, 0, 1), "preload_start");
    step(0, 0, 1, 0, 0, 4'd0, mk(0, 1, 1, 0, 2), "preload_wrap");

    // ---------------- MAX_VAL = 1, WIDTH = 2 ----------------
    sel = 2;
    step(1, 0, 0, 0, 0, 4'd0, mk(0, 0, 0, 0, 0), "rst_c");
    step(0, 1, 1, 0, 0, 4'd0, mk(0, 0, 1, 0, 0), "sat_start");
    for (int i = 1; i <= 600; i++)
      step(0, 0, 1, 0, 0, 4'd0, mk(i % 2, (i % 2) == 0, 1, 0, (i / 2 > 255) ? 255 : i / 2), "sat");

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
